// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types and defaults for the unified-memory arbiter.
package cpu_pkg;

    // Arbiter FSM encoding
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FETCH = 2'b01,
        DATA  = 2'b10
    } arbStateT;

    // Winner of one arbitration round
    typedef enum logic [1:0] {
        GNT_NONE = 2'b00,
        GNT_F    = 2'b01,
        GNT_M    = 2'b10
    } grantT;

    // Consecutive data grants allowed while fetch is waiting
    localparam int MAX_DATA_RUN_DEF = 4;

    // Width needed to count 0..maxRun inclusive
    function automatic int cntWidth(input int maxRun);
        return $clog2(maxRun + 1);
    endfunction

endpackage

// File: rtl/starve_cnt.sv
// starve_cnt: saturating counter of data grants made while fetch waits.
module starve_cnt
    import cpu_pkg::*;
#(
    parameter int MAX_DATA_RUN = MAX_DATA_RUN_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic sat
);
    localparam int CW = cntWidth(MAX_DATA_RUN);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_DATA_RUN);

    logic [CW-1:0] cnt;

    // Clear wins over increment; hold once the limit is reached
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != CNT_MAX)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign sat = (cnt == CNT_MAX);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between fetch (F) and memory stage (M).
// Data wins by default; a starvation counter forces a fetch grant after
// MAX_DATA_RUN consecutive data grants. Grants are made in IDLE and on the
// mem_ready cycle of the running transaction, so transactions can run back-to-back.
module mem_arbiter
    import cpu_pkg::*;
#(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int MAX_DATA_RUN = MAX_DATA_RUN_DEF
) (
    input  logic          clk,
    input  logic          reset,
    // fetch stage
    input  logic          fetch_req,
    input  logic [AW-1:0] fetch_addr,
    input  logic          fetch_cancel,
    output logic          fetch_done,
    output logic [DW-1:0] fetch_rdata,
    // memory stage
    input  logic          data_req,
    input  logic          data_we,
    input  logic [AW-1:0] data_addr,
    input  logic [DW-1:0] data_wdata,
    output logic          data_done,
    output logic [DW-1:0] data_rdata,
    // memory side
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready,
    // hazard unit
    output logic          StallF,
    output logic          StallM
);
    arbStateT state, stateNext;
    grantT    grant;
    logic     fetchElig, dataElig;
    logic     complete, arbitrate;
    logic     fetchAborted;
    logic     cntInc, cntClr, cntSat;

    // Eligibility and winner selection; a requester whose done is pulsing
    // still shows its old request and must not be served twice
    always_comb begin
        fetchElig = fetch_req & ~fetch_done;
        dataElig  = data_req & ~data_done;
        complete  = (state != IDLE) & mem_ready;
        arbitrate = (state == IDLE) | complete;
        grant     = GNT_NONE;
        if (arbitrate) begin
            if (dataElig && (!fetchElig || !cntSat)) begin
                grant = GNT_M;
            end else if (fetchElig && !fetch_cancel) begin
                grant = GNT_F;
            end
        end
    end

    // Next state follows the grant whenever an arbitration round happens
    always_comb begin
        stateNext = state;
        if (arbitrate) begin
            case (grant)
                GNT_M:   stateNext = DATA;
                GNT_F:   stateNext = FETCH;
                default: stateNext = IDLE;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Starvation tracking: count data wins over a waiting fetch
    assign cntInc = (grant == GNT_M) & fetch_req;
    assign cntClr = (grant == GNT_F) | ~fetch_req;

    starve_cnt #(
        .MAX_DATA_RUN (MAX_DATA_RUN)
    ) uCnt (
        .clk   (clk),
        .reset (reset),
        .inc   (cntInc),
        .clr   (cntClr),
        .sat   (cntSat)
    );

    // Command latch, done pulses and read-data capture
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            fetch_done   <= 1'b0;
            data_done    <= 1'b0;
            fetch_rdata  <= '0;
            data_rdata   <= '0;
            fetchAborted <= 1'b0;
        end else begin
            // a cancelled fetch still completes on the bus but reports nothing
            fetch_done <= complete && (state == FETCH) && !fetchAborted && !fetch_cancel;
            data_done  <= complete && (state == DATA);

            if (complete && (state == FETCH) && !fetchAborted && !fetch_cancel) begin
                fetch_rdata <= mem_rdata;
            end
            if (complete && (state == DATA)) begin
                data_rdata <= mem_rdata;
            end

            if (grant != GNT_NONE) begin
                fetchAborted <= 1'b0;
            end else if ((state == FETCH) && fetch_cancel) begin
                fetchAborted <= 1'b1;
            end

            case (grant)
                GNT_M: begin
                    mem_req   <= 1'b1;
                    mem_we    <= data_we;
                    mem_addr  <= data_addr;
                    mem_wdata <= data_wdata;
                end
                GNT_F: begin
                    mem_req   <= 1'b1;
                    mem_we    <= 1'b0;
                    mem_addr  <= fetch_addr;
                    mem_wdata <= '0;
                end
                default: begin
                    if (complete) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Stall whoever is waiting on the shared port
    assign StallF = fetch_req & ~fetch_done;
    assign StallM = data_req & ~data_done;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed tests for mem_arbiter against a small memory model.
module tb_mem_arbiter;

    logic        clk;
    logic        reset;
    logic        fetch_req, fetch_cancel, fetch_done;
    logic [31:0] fetch_addr, fetch_rdata;
    logic        data_req, data_we, data_done;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic        mem_req, mem_we, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        StallF, StallM;

    int nChk = 0;
    int nErr = 0;
    int lat  = 1;
    int age;
    logic [31:0] memArr [0:255];

    mem_arbiter #(.AW(32), .DW(32), .MAX_DATA_RUN(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .fetch_req    (fetch_req),
        .fetch_addr   (fetch_addr),
        .fetch_cancel (fetch_cancel),
        .fetch_done   (fetch_done),
        .fetch_rdata  (fetch_rdata),
        .data_req     (data_req),
        .data_we      (data_we),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_done    (data_done),
        .data_rdata   (data_rdata),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ready    (mem_ready),
        .StallF       (StallF),
        .StallM       (StallM)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: ready 'lat' cycles after the first mem_req cycle of a transaction
    always @(posedge clk) begin
        if (reset) begin
            age <= 0;
            for (int i = 0; i < 256; i++) memArr[i] <= 32'hC0DE_0000 | (32'(i) << 2);
        end else begin
            if (mem_req && mem_ready) begin
                age <= 0;
                if (mem_we) memArr[mem_addr[9:2]] <= mem_wdata;
            end else if (mem_req) begin
                age <= age + 1;
            end
        end
    end

    assign mem_ready = mem_req && (age == lat);
    assign mem_rdata = memArr[mem_addr[9:2]];

    function automatic logic [31:0] word(input logic [31:0] a);
        return 32'hC0DE_0000 | a;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChk++;
        if (got !== exp) begin
            nErr++;
            $display("FAIL %s: got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        fetch_req = 0; fetch_addr = 0; fetch_cancel = 0;
        data_req = 0; data_we = 0; data_addr = 0; data_wdata = 0;
        tick(); tick();

        // reset state
        chk("rst mem_req", 64'(mem_req), 0);
        chk("rst mem_we", 64'(mem_we), 0);
        chk("rst fdone", 64'(fetch_done), 0);
        chk("rst ddone", 64'(data_done), 0);
        chk("rst StallF", 64'(StallF), 0);
        chk("rst StallM", 64'(StallM), 0);
        chk("rst mem_addr", 64'(mem_addr), 0);
        chk("rst frdata", 64'(fetch_rdata), 0);
        chk("rst state", 64'(dut.state), 0);
        reset = 1'b0;

        // 1: fetch 0x00 then 0x04, 1-cycle memory
        fetch_req = 1; fetch_addr = 32'h00;
        tick();
        chk("t1 mem_req", 64'(mem_req), 1);
        chk("t1 addr0", 64'(mem_addr), 32'h00);
        chk("t1 StallF wait", 64'(StallF), 1);
        tick();                      // ready cycle: present next PC
        fetch_addr = 32'h04;
        tick();
        chk("t1 done0", 64'(fetch_done), 1);
        chk("t1 rdata0", 64'(fetch_rdata), word(32'h00));
        chk("t1 StallF done", 64'(StallF), 0);
        chk("t1 addr4", 64'(mem_addr), 32'h04);
        tick();                      // ready for 0x04
        chk("t1 gap", 64'(fetch_done), 0);
        fetch_req = 0;
        tick();
        chk("t1 done1", 64'(fetch_done), 1);
        chk("t1 rdata1", 64'(fetch_rdata), word(32'h04));
        chk("t1 idle", 64'(mem_req), 0);
        tick();

        // 2: fetch and load rise together, data first then fetch back-to-back
        fetch_req = 1; fetch_addr = 32'h08;
        data_req = 1; data_we = 0; data_addr = 32'h100;
        tick();
        chk("t2 data first", 64'(mem_addr), 32'h100);
        chk("t2 StallF", 64'(StallF), 1);
        chk("t2 StallM", 64'(StallM), 1);
        tick();
        chk("t2 req hold", 64'(mem_req), 1);
        data_req = 0;
        tick();
        chk("t2 ddone", 64'(data_done), 1);
        chk("t2 drdata", 64'(data_rdata), word(32'h100));
        chk("t2 req b2b", 64'(mem_req), 1);
        chk("t2 fetch next", 64'(mem_addr), 32'h08);
        chk("t2 StallF", 64'(StallF), 1);
        tick();
        fetch_req = 0;
        tick();
        chk("t2 fdone", 64'(fetch_done), 1);
        chk("t2 frdata", 64'(fetch_rdata), word(32'h08));

        // 3: held loads with fetch waiting -> M,M,M,M,F,M
        data_req = 1; data_we = 0; data_addr = 32'h200;
        fetch_req = 1; fetch_addr = 32'h0C;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk($sformatf("t3 gnt%0d", k), 64'(mem_addr), (k == 4) ? 64'h0C : 64'h200);
            tick();
        end
        chk("t3 cnt restart", 64'(dut.uCnt.cnt), 1);
        chk("t3 frdata", 64'(fetch_rdata), word(32'h0C));
        data_req = 0; fetch_req = 0;
        tick();
        chk("t3 ddone", 64'(data_done), 1);
        chk("t3 idle", 64'(mem_req), 0);
        tick();

        // 4: store with 3-cycle memory, then read back
        lat = 3;
        data_req = 1; data_we = 1; data_addr = 32'h20; data_wdata = 32'hDEADBEEF;
        tick();
        data_wdata = 32'h0;          // bus may move once the command is latched
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("t4 addr c%0d", k), 64'(mem_addr), 32'h20);
            chk($sformatf("t4 wdata c%0d", k), 64'(mem_wdata), 32'hDEADBEEF);
            chk($sformatf("t4 we c%0d", k), 64'(mem_we), 1);
            chk($sformatf("t4 nodone c%0d", k), 64'(data_done), 0);
            if (k == 3) data_req = 0;
            else tick();
        end
        tick();
        chk("t4 ddone", 64'(data_done), 1);
        tick();
        chk("t4 once", 64'(data_done), 0);
        lat = 1;
        data_req = 1; data_we = 0; data_addr = 32'h20;
        tick();
        chk("t4 ld we", 64'(mem_we), 0);
        tick();
        data_req = 0;
        tick();
        chk("t4 ld done", 64'(data_done), 1);
        chk("t4 ld rdata", 64'(data_rdata), 32'hDEADBEEF);
        tick();

        // 5: cancel during FETCH 0x40, redirect to 0x80
        fetch_req = 1; fetch_addr = 32'h40;
        tick();
        chk("t5 addr40", 64'(mem_addr), 32'h40);
        fetch_cancel = 1; fetch_addr = 32'h80;
        tick();
        fetch_cancel = 0;
        chk("t5 latched", 64'(mem_addr), 32'h40);
        tick();
        chk("t5 no fdone", 64'(fetch_done), 0);
        chk("t5 rdata held", 64'(fetch_rdata), word(32'h0C));
        chk("t5 addr80", 64'(mem_addr), 32'h80);
        tick();
        fetch_req = 0;
        tick();
        chk("t5 fdone", 64'(fetch_done), 1);
        chk("t5 frdata", 64'(fetch_rdata), word(32'h80));
        tick();

        // 6: reset in the middle of a DATA transaction
        lat = 3;
        data_req = 1; data_we = 0; data_addr = 32'h104;
        tick();
        chk("t6 busy", 64'(mem_req), 1);
        tick();
        reset = 1;
        tick();
        chk("t6 rst req", 64'(mem_req), 0);
        chk("t6 rst state", 64'(dut.state), 0);
        chk("t6 rst ddone", 64'(data_done), 0);
        chk("t6 rst drdata", 64'(data_rdata), 0);
        chk("t6 rst frdata", 64'(fetch_rdata), 0);
        reset = 0;
        tick();
        chk("t6 reissue", 64'(mem_addr), 32'h104);
        chk("t6 no ddone", 64'(data_done), 0);
        tick(); tick(); tick();
        data_req = 0;
        tick();
        chk("t6 ddone", 64'(data_done), 1);
        chk("t6 drdata", 64'(data_rdata), word(32'h104));
        tick();

        $display("Simulation finished: %0d checks, %0d errors", nChk, nErr);
        $finish;
    end

endmodule
